multdiv_controller: RTL

Sequencer for the iterative multiply/divide unit used by the execute stage of the 5-stage pipeline. It detects a `mul` or `div` instruction sitting in the D/X latch and latches its operands. It issues a single start pulse to the unit, then holds the pipeline stalled until the unit reports ready or a timeout expires. On completion it presents either the result for the `$rd` write path or an exception code for the `$r30` (`$rstatus`) write path, for exactly one cycle.

---
 rtl/multdiv_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_controller.sv
// Sequencer for the iterative multiply/divide unit in the execute stage.
// Captures mul/div operands, pulses start, stalls until ready or timeout, then reports once.
module multdiv_controller #(
  parameter int unsigned TIMEOUT    = 40,
  parameter logic [31:0] MUL_STATUS = 32'd4,
  parameter logic [31:0] DIV_STATUS = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_x,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        kill,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        status_we,
  output logic [31:0] status_value,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]  MUL_FUNCT = 5'b00110;
  localparam logic [4:0]  DIV_FUNCT = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] count_q;
  logic          op_div_q;
  logic          exc_q;

  logic          is_mul_c;
  logic          is_div_c;
  logic          is_md_c;
  logic          latch_c;
  logic          fin_ready_c;
  logic          fin_timeout_c;
  logic          timeout_hit_c;
  logic          unused_insn_c;

  // Opcode field must be zero and the funct field must select mul or div.
  assign is_mul_c      = (insn_x[31:27] == 5'b00000) && (insn_x[6:2] == MUL_FUNCT);
  assign is_div_c      = (insn_x[31:27] == 5'b00000) && (insn_x[6:2] == DIV_FUNCT);
  assign is_md_c       = is_mul_c || is_div_c;
  assign timeout_hit_c = (count_q == CW'(TIMEOUT - 1));
  assign unused_insn_c = ^{insn_x[26:7], insn_x[1:0]};

  assign busy = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and single-cycle control outputs.
  always_comb begin
    state_d       = state_q;
    latch_c       = 1'b0;
    fin_ready_c   = 1'b0;
    fin_timeout_c = 1'b0;
    md_ctrl_mult  = 1'b0;
    md_ctrl_div   = 1'b0;
    result_valid  = 1'b0;
    status_we     = 1'b0;
    stall         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_md_c && !kill) begin
          latch_c = 1'b1;
          stall   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        stall        = 1'b1;
        md_ctrl_mult = !kill && !op_div_q;
        md_ctrl_div  = !kill && op_div_q;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (md_ready) begin
          fin_ready_c = 1'b1;
          state_d     = S_DONE;
        end else if (timeout_hit_c) begin
          fin_timeout_c = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = !kill && !exc_q;
        status_we    = !kill && exc_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A squash abandons whatever is in flight, including a same-cycle completion.
    if (kill) begin
      state_d       = S_IDLE;
      fin_ready_c   = 1'b0;
      fin_timeout_c = 1'b0;
    end

    // Keep the pipeline free while the block is held in reset.
    if (!reset) begin
      stall = 1'b0;
    end
  end

  // Operand latches, WAIT counter and completion capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_operand_a <= '0;
      md_operand_b <= '0;
      op_div_q     <= 1'b0;
      count_q      <= '0;
      result       <= '0;
      exc_q        <= 1'b0;
      status_value <= '0;
    end else begin
      if (latch_c) begin
        md_operand_a <= operand_a;
        md_operand_b <= operand_b;
        op_div_q     <= is_div_c;
      end
      if (state_q == S_START) begin
        count_q <= '0;
      end else if (state_q == S_WAIT) begin
        count_q <= count_q + CW'(1);
      end
      if (fin_ready_c || fin_timeout_c) begin
        result       <= fin_ready_c ? md_result : DW'(0);
        exc_q        <= fin_ready_c ? md_exception : 1'b1;
        status_value <= op_div_q ? DIV_STATUS : MUL_STATUS;
      end
    end
  end

endmodule
